// File: rtl/mips_dmem_dump.sv
// mips_dmem_dump
// Streams a contiguous range of 32-bit data-memory words out as bytes,
// most significant byte first, over a valid/ready byte interface.
// Used to read results back after a program run while the core is halted.
//
// Optional feature: define DMEM_DUMP_CHECKSUM_EN to append one checksum byte
// (sum mod 256 of all transferred data bytes) after the last word.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start_i           - one-cycle start request, honoured only when idle
//   base_addr_i       - first word index, captured on accepted start
//   word_count_i      - number of words (0..MEM_DEPTH), captured on start
//   mem_rd_en_o       - read strobe to data memory (one cycle per word)
//   mem_rd_addr_o     - word address for the read
//   mem_rd_data_i     - read data, valid the cycle after mem_rd_en_o
//   tx_data_o         - output byte
//   tx_valid_o        - output byte valid
//   tx_ready_i        - sink ready; transfer when valid and ready
//   busy_o            - high whenever not idle
//   done_o            - one-cycle pulse at the end of a dump
module mips_dmem_dump #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [AW:0]   word_count_i,
  output logic          mem_rd_en_o,
  output logic [AW-1:0] mem_rd_addr_o,
  input  logic [31:0]   mem_rd_data_i,
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  output logic          busy_o,
  output logic          done_o
);

`ifdef DMEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_SEND, S_CSUM, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_SEND, S_DONE
  } state_t;
`endif

  state_t        state_reg;
  logic [AW-1:0] base_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   words_sent_reg;
  logic [1:0]    byte_idx_reg;
  logic [31:0]   shift_reg;
`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [7:0]    csum_reg;
`endif

  // Word counter value after the current word completes; used both for the
  // "more words?" decision and to form the next read address.
  logic [AW:0] words_sent_next;
  assign words_sent_next = words_sent_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      base_reg       <= '0;
      count_reg      <= '0;
      words_sent_reg <= '0;
      byte_idx_reg   <= '0;
      shift_reg      <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
      csum_reg       <= '0;
`endif
      mem_rd_en_o    <= 1'b0;
      mem_rd_addr_o  <= '0;
      tx_data_o      <= '0;
      tx_valid_o     <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            base_reg       <= base_addr_i;
            count_reg      <= word_count_i;
            words_sent_reg <= '0;
            byte_idx_reg   <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            csum_reg       <= '0;
`endif
            busy_o         <= 1'b1;
            if (word_count_i != '0) begin
              state_reg     <= S_READ;
              mem_rd_en_o   <= 1'b1;
              mem_rd_addr_o <= base_addr_i;
            end else begin
`ifdef DMEM_DUMP_CHECKSUM_EN
              // Empty dump still emits the (zero) checksum byte.
              state_reg  <= S_CSUM;
              tx_valid_o <= 1'b1;
              tx_data_o  <= 8'h00;
`else
              state_reg <= S_DONE;
              done_o    <= 1'b1;
`endif
            end
          end
        end

        S_READ: begin
          mem_rd_en_o <= 1'b0;
          state_reg   <= S_LOAD;
        end

        S_LOAD: begin
          shift_reg  <= mem_rd_data_i;
          tx_data_o  <= mem_rd_data_i[31:24];
          tx_valid_o <= 1'b1;
          state_reg  <= S_SEND;
        end

        S_SEND: begin
          // Output byte only changes on a handshake, so it is stable in stalls.
          if (tx_ready_i) begin
            shift_reg    <= {shift_reg[23:0], 8'h00};
            tx_data_o    <= shift_reg[23:16];
            byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef DMEM_DUMP_CHECKSUM_EN
            csum_reg     <= csum_reg + tx_data_o;
`endif
            if (byte_idx_reg == 2'd3) begin
              words_sent_reg <= words_sent_next;
              tx_valid_o     <= 1'b0;
              if (words_sent_next == count_reg) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                // Fold in the byte being transferred right now.
                state_reg  <= S_CSUM;
                tx_valid_o <= 1'b1;
                tx_data_o  <= csum_reg + tx_data_o;
`else
                state_reg <= S_DONE;
                done_o    <= 1'b1;
`endif
              end else begin
                state_reg     <= S_READ;
                mem_rd_en_o   <= 1'b1;
                // AW-bit sum wraps modulo MEM_DEPTH.
                mem_rd_addr_o <= base_reg + words_sent_next[AW-1:0];
              end
            end
          end
        end

`ifdef DMEM_DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            state_reg  <= S_DONE;
            done_o     <= 1'b1;
          end
        end
`endif

        S_DONE: begin
          done_o    <= 1'b0;
          busy_o    <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_dump.sv
// Directed testbench for mips_dmem_dump: data memory model, byte/read/done
// monitor on the falling edge, and a linear sequence of directed dumps with
// hand-computed expected bytes and cycle positions.
module tb_mips_dmem_dump;

`ifdef DMEM_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  base_addr_i;
  logic [8:0]  word_count_i;
  logic        mem_rd_en_o;
  logic [7:0]  mem_rd_addr_o;
  logic [31:0] mem_rd_data_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        done_o;

  mips_dmem_dump #(.MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .base_addr_i(base_addr_i), .word_count_i(word_count_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o),
    .mem_rd_data_i(mem_rd_data_i), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Data memory with a one-cycle synchronous read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled mid-cycle, so valid&ready here means a transfer at the
  // next rising edge.
  logic [7:0] byteq[$];
  int         rdq[$];
  int         done_cnt = 0;
  int         done_last = 0;
  int         stab_err = 0;
  logic       stalled = 1'b0;
  logic [7:0] held = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en_o) rdq.push_back(int'(mem_rd_addr_o));
      if (tx_valid_o && tx_ready_i) begin
        byteq.push_back(tx_data_o);
        $display("byte %02h at cycle %0d", tx_data_o, cyc);
      end
      if (stalled && (!tx_valid_o || tx_data_o !== held)) stab_err <= stab_err + 1;
      stalled <= tx_valid_o && !tx_ready_i;
      held    <= tx_data_o;
      if (done_o) begin
        done_cnt  <= done_cnt + 1;
        done_last <= cyc + 1;
      end
    end else begin
      stalled <= 1'b0;
    end
  end

  int errors = 0;
  int checks = 0;
  int start_cyc;
  int pat[4] = '{1, 0, 0, 1};
  logic [7:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bytes(input string tag, input int b0);
    chk({tag, "_nbytes"}, 32'(byteq.size() - b0), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (b0 + i < byteq.size()) chk({tag, "_byte"}, {24'h0, byteq[b0 + i]}, {24'h0, expq[i]});
      else chk({tag, "_byte_missing"}, 32'hFFFF_FFFF, {24'h0, expq[i]});
    end
  endtask

  // Start a dump and wait (bounded) for done_o; inj>0 pulses start_i again
  // inj cycles after start with a different base address.
  task automatic run_dump(input int base, input int cnt, input int mode, input int inj);
    int d0;
    int k;
    d0 = done_cnt;
    @(posedge clk); #1;
    base_addr_i  = 8'(base);
    word_count_i = 9'(cnt);
    start_i      = 1'b1;
    tx_ready_i   = 1'b1;
    start_cyc    = cyc + 1;
    k = 0;
    while (done_cnt == d0 && k < 400) begin
      @(posedge clk); #1;
      k++;
      start_i = (inj != 0 && k == inj);
      if (start_i) base_addr_i = 8'd100;
      tx_ready_i = (mode != 0) ? pat[k % 4][0] : 1'b1;
    end
    start_i    = 1'b0;
    tx_ready_i = 1'b1;
    chk("done_timeout", 32'(k < 400), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  int b0, r0, d0, k;

  initial begin
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; word_count_i = '0; tx_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h20010001; mem[1] = 32'h20020002; mem[2] = 32'hafef0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", {31'h0, mem_rd_en_o}, 32'h0);
    chk("rst_rd_addr", {24'h0, mem_rd_addr_o}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    rst = 1'b0;

    // Three-word dump, ready held high.
    expq = '{8'h20, 8'h01, 8'h00, 8'h01, 8'h20, 8'h02, 8'h00, 8'h02,
             8'hAF, 8'hEF, 8'h00, 8'h00};
    if (CS != 0) expq.push_back(8'hE4);
    b0 = byteq.size(); r0 = rdq.size(); d0 = done_cnt;
    run_dump(0, 3, 0, 0);
    $display("dump base=0 count=3 ready=1 done_cycle=%0d", done_last - start_cyc);
    chk_bytes("basic", b0);
    chk("basic_done_cycle", 32'(done_last - start_cyc), 32'(19 + CS));
    chk("basic_done_count", 32'(done_cnt - d0), 32'd1);
    chk("basic_nreads", 32'(rdq.size() - r0), 32'd3);
    for (int i = 0; i < 3; i++) chk("basic_rd_addr", 32'(rdq[r0 + i]), 32'(i));
    chk("idle_busy", {31'h0, busy_o}, 32'h0);

    // Same dump with ready pattern 1-0-0-1.
    b0 = byteq.size(); d0 = done_cnt; k = stab_err;
    run_dump(0, 3, 1, 0);
    $display("dump base=0 count=3 ready=1001 bytes=%0d", byteq.size() - b0);
    chk_bytes("bp", b0);
    chk("bp_stable", 32'(stab_err - k), 32'd0);
    chk("bp_done_count", 32'(done_cnt - d0), 32'd1);

    // Zero-length dump.
    expq = '{};
    if (CS != 0) expq.push_back(8'h00);
    b0 = byteq.size(); r0 = rdq.size(); d0 = done_cnt;
    run_dump(5, 0, 0, 0);
    $display("dump count=0 done_cycle=%0d", done_last - start_cyc);
    chk_bytes("zero", b0);
    chk("zero_nreads", 32'(rdq.size() - r0), 32'd0);
    chk("zero_done_cycle", 32'(done_last - start_cyc), 32'(1 + CS));

    // start_i pulsed during SEND is ignored.
    expq = '{8'h20, 8'h01, 8'h00, 8'h01, 8'h20, 8'h02, 8'h00, 8'h02,
             8'hAF, 8'hEF, 8'h00, 8'h00};
    if (CS != 0) expq.push_back(8'hE4);
    b0 = byteq.size(); d0 = done_cnt;
    run_dump(0, 3, 0, 4);
    $display("dump with start during SEND done_cycle=%0d", done_last - start_cyc);
    chk_bytes("inj", b0);
    chk("inj_done_cycle", 32'(done_last - start_cyc), 32'(19 + CS));
    chk("inj_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset after the 5th transferred byte.
    b0 = byteq.size(); d0 = done_cnt;
    @(posedge clk); #1;
    base_addr_i = 8'd0; word_count_i = 9'd3; start_i = 1'b1;
    k = 0;
    while (byteq.size() - b0 < 5 && k < 100) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      k++;
    end
    chk("rstmid_timeout", 32'(k < 100), 32'd1);
    chk("rstmid_5th_byte", {24'h0, byteq[b0 + 4]}, 32'h20);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-dump after byte 5");
    chk("rstmid_outputs", {mem_rd_en_o, mem_rd_addr_o, tx_data_o, tx_valid_o, busy_o, done_o}, 32'h0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    expq = '{8'h20, 8'h01, 8'h00, 8'h01};
    if (CS != 0) expq.push_back(8'h22);
    b0 = byteq.size();
    run_dump(0, 1, 0, 0);
    $display("fresh dump base=0 count=1 done_cycle=%0d", done_last - start_cyc);
    chk_bytes("fresh", b0);
    chk("fresh_done_cycle", 32'(done_last - start_cyc), 32'(7 + CS));

    // Address wrap across the top of memory.
    mem[254] = 32'h11111111; mem[255] = 32'h22222222; mem[0] = 32'h33333333;
    expq = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
             8'h33, 8'h33, 8'h33, 8'h33};
    if (CS != 0) expq.push_back(8'h98);
    b0 = byteq.size(); r0 = rdq.size();
    run_dump(254, 3, 0, 0);
    $display("dump base=254 count=3 reads=%0d", rdq.size() - r0);
    chk_bytes("wrap", b0);
    chk("wrap_nreads", 32'(rdq.size() - r0), 32'd3);
    chk("wrap_rd0", 32'(rdq[r0]), 32'd254);
    chk("wrap_rd1", 32'(rdq[r0 + 1]), 32'd255);
    chk("wrap_rd2", 32'(rdq[r0 + 2]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_dmem_dump.md
# mips_dmem_dump

Data-memory dump engine for the MIPS core: on a start pulse it reads a contiguous range of 32-bit words from the data memory's synchronous read port and streams them out as bytes, most significant byte first, over a valid/ready byte interface. It is the read-back counterpart of memory preloading and lets a bench or debug link retrieve results after a program run. It sits beside `MIPS_core`, sharing the data memory through a dedicated read port while the core is halted or held in reset.

## Interface
- `MEM_DEPTH`, 256: number of 32-bit words in data memory; power of two.
- `AW`, `$clog2(MEM_DEPTH)`: word-address width.
- `clk` in 1: clock; all logic rising-edge.
- `rst` in 1: reset; synchronous, active-high.
- `start_i` in 1: one-cycle start request; sampled only in IDLE.
- `base_addr_i` in AW: first word index; captured on accepted start.
- `word_count_i` in AW+1: number of words, 0..MEM_DEPTH; captured on accepted start.
- `mem_rd_en_o` out 1: read strobe to data memory.
- `mem_rd_addr_o` out AW: word address for the read.
- `mem_rd_data_i` in 32: read data, valid the cycle after `mem_rd_en_o`.
- `tx_data_o` out 8: output byte.
- `tx_valid_o` out 1: byte valid.
- `tx_ready_i` in 1: sink ready; a byte transfers when valid and ready are both high.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse at the end of a dump.

## Operation
- States: IDLE, READ, LOAD, SEND, CSUM (only when configured), DONE.
- IDLE: on `start_i`, capture the base address and count, and clear the byte index and checksum. If the count is nonzero, go to READ; otherwise go to CSUM if configured, else DONE.
- READ: assert `mem_rd_en_o` for exactly one cycle, with `mem_rd_addr_o` = (base + words_sent) mod MEM_DEPTH. Then go to LOAD.
- LOAD: capture `mem_rd_data_i` into a 32-bit shift register, then go to SEND.
- SEND: `tx_valid_o` = 1 and `tx_data_o` = shift[31:24].
  - On each handshake, shift left by 8 and increment the byte index.
  - After the 4th handshake, increment words_sent.
  - If more words remain, go to READ; otherwise go to CSUM if configured, else DONE.
- DONE: pulse `done_o`, then return to IDLE.
- Address arithmetic wraps modulo MEM_DEPTH. For example, base MEM_DEPTH-1 followed by one more word reads address 0.
- `start_i` outside IDLE is ignored.
- `tx_data_o` must remain stable while `tx_valid_o` is high and `tx_ready_i` is low.
- `mem_rd_en_o` is never asserted outside READ.

## Timing
- Reset values of all outputs are 0 (`mem_rd_en_o`, `mem_rd_addr_o`, `tx_data_o`, `tx_valid_o`, `busy_o`, `done_o`), and the state is IDLE.
- Reset asserted mid-dump aborts the dump within one cycle. No `done_o` pulse is generated, and the next start begins a fresh dump.
- `start_i` sampled at edge N: READ occupies cycle N+1, LOAD occupies N+2, and the first byte is valid in N+3.
- Per word with `tx_ready_i` held at 1: READ + LOAD + 4 SEND cycles, i.e. 6 cycles per word.
- For a count of W words with ready held at 1, `done_o` is high 6W+1 cycles after start, or 6W+2 with checksum enabled.
- With a count of 0, `done_o` is high 1 cycle after start (2 cycles with checksum enabled).
- Backpressure stalls only the SEND and CSUM states; there is no byte loss or duplication.

## Configuration
- `DMEM_DUMP_CHECKSUM_EN` defined:
  - An 8-bit checksum is maintained as the sum modulo 256 of every transferred data byte.
  - After the last word, the CSUM state presents the checksum with `tx_valid_o`=1 and holds it until handshake, then goes to DONE.
  - With a count of 0, CSUM sends 0x00.
- `DMEM_DUMP_CHECKSUM_EN` undefined: the CSUM state and the checksum register are absent, and SEND goes directly to DONE.

## Test plan
- Preload mem[0..2] = 0x20010001, 0x20020002, 0xafef0000; start with base 0, count 3, ready held at 1 -> bytes 20 01 00 01 20 02 00 02 AF EF 00 00, then a `done_o` pulse at cycle 19 after start. With checksum enabled, an extra byte E4 follows and `done_o` is at cycle 20.
- Same dump with `tx_ready_i` toggling 1-0-0-1 -> the identical byte sequence; `tx_data_o` is held stable during every stall and exactly 12 handshakes occur (13 with checksum).
- MEM_DEPTH 256, base 254, count 3, with mem[254]=0x11111111, mem[255]=0x22222222, mem[0]=0x33333333 -> read addresses 254, 255, 0; bytes 11×4, 22×4, 33×4.
- Start with count 0 -> no `mem_rd_en_o`; `done_o` 1 cycle after start (with checksum enabled: a single byte 00, then `done_o`).
- Assert `rst` after the 5th byte of a 3-word dump -> next cycle all outputs are 0 and there is no `done_o`. A fresh start with base 0, count 1 then emits 20 01 00 01.
- Pulse `start_i` during SEND -> it is ignored; the dump completes unchanged and `done_o` pulses once.
